// File: rtl/memory_access.sv
// memory_access: memory stage of the in-order pipeline, upstream of writeback.
// Executes LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack data-memory port and emits
// a registered result bundle. Non-memory and misaligned instructions complete
// in one cycle; memory instructions stall upstream until ack or timeout.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, code, rd,       instruction from execute (code: [6:0] opcode,
//   writeEnabled, aluResult,  [9:7] funct3); aluResult is the effective address
//   storeData                 for memory ops, storeData is rs2
//   stall                     high while a memory transaction is in flight
//   mem_req/we/be/addr/wdata  registered data-memory request
//   mem_rdata, mem_ack        read data and one-cycle completion pulse
//   out_valid, rd_out, writeEnabled_out, code_out, dataAlu_out,
//   memAddress_out, misaligned, bus_error   registered writeback bundle
module memory_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [11:0] code,
  input  logic [4:0]  rd,
  input  logic        writeEnabled,
  input  logic [31:0] aluResult,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  output logic [4:0]  rd_out,
  output logic        writeEnabled_out,
  output logic [11:0] code_out,
  output logic [31:0] dataAlu_out,
  output logic [31:0] memAddress_out,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_next;
  logic [7:0] cnt;

  // Decode of the presented instruction
  logic       in_load, in_store, in_byte, in_half, in_word, in_unsigned, in_mis;
  logic [2:0] f3;

  // Instruction captured while the memory transaction is outstanding
  logic [4:0]  c_rd;
  logic        c_we;
  logic [11:0] c_code;
  logic [31:0] c_alu;
  logic        c_load, c_store, c_byte, c_half, c_unsigned;

  // FSM strobes
  logic accept_mem, emit_direct, emit_ack, emit_timeout;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  always_comb begin
    f3          = code[9:7];
    in_load     = (code[6:0] == OP_LOAD);
    in_store    = (code[6:0] == OP_STORE);
    in_byte     = 1'b0;
    in_half     = 1'b0;
    in_unsigned = 1'b0;
    if (in_load) begin
      // Undefined load funct3 values fall through to word size.
      in_byte     = (f3 == 3'b000) || (f3 == 3'b100);
      in_half     = (f3 == 3'b001) || (f3 == 3'b101);
      in_unsigned = (f3 == 3'b100) || (f3 == 3'b101);
    end else if (in_store) begin
      in_byte = (f3 == 3'b000);
      in_half = (f3 == 3'b001);
    end
    in_word = ~in_byte & ~in_half;
    in_mis  = (in_load | in_store) &
              ((in_half & aluResult[0]) | (in_word & (aluResult[1:0] != 2'b00)));
  end

  always_comb begin
    if (in_byte) begin
      be_next    = 4'b0001 << aluResult[1:0];
      wdata_next = {4{storeData[7:0]}};
    end else if (in_half) begin
      be_next    = aluResult[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{storeData[15:0]}};
    end else begin
      be_next    = 4'b1111;
      wdata_next = storeData;
    end
  end

  always_comb begin
    case (c_alu[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = c_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (c_byte) begin
      load_data = {{24{~c_unsigned & byte_sel[7]}}, byte_sel};
    end else if (c_half) begin
      load_data = {{16{~c_unsigned & half_sel[15]}}, half_sel};
    end else begin
      load_data = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    accept_mem   = 1'b0;
    emit_direct  = 1'b0;
    emit_ack     = 1'b0;
    emit_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if ((in_load | in_store) & ~in_mis) begin
            accept_mem = 1'b1;
            state_next = WAIT;
          end else begin
            emit_direct = 1'b1;
          end
        end
      end
      WAIT: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (mem_ack) begin
          emit_ack   = 1'b1;
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          emit_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall = (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt              <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_be           <= '0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      out_valid        <= 1'b0;
      rd_out           <= '0;
      writeEnabled_out <= 1'b0;
      code_out         <= '0;
      dataAlu_out      <= '0;
      memAddress_out   <= '0;
      misaligned       <= 1'b0;
      bus_error        <= 1'b0;
      c_rd             <= '0;
      c_we             <= 1'b0;
      c_code           <= '0;
      c_alu            <= '0;
      c_load           <= 1'b0;
      c_store          <= 1'b0;
      c_byte           <= 1'b0;
      c_half           <= 1'b0;
      c_unsigned       <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;

      if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end

      if (state == IDLE && in_valid) begin
        c_rd       <= rd;
        c_we       <= writeEnabled;
        c_code     <= code;
        c_alu      <= aluResult;
        c_load     <= in_load;
        c_store    <= in_store;
        c_byte     <= in_byte;
        c_half     <= in_half;
        c_unsigned <= in_unsigned;
      end

      if (accept_mem) begin
        cnt       <= '0;
        mem_req   <= 1'b1;
        mem_we    <= in_store;
        mem_be    <= be_next;
        mem_addr  <= {aluResult[31:2], 2'b00};
        mem_wdata <= wdata_next;
      end

      if (emit_direct) begin
        out_valid        <= 1'b1;
        rd_out           <= rd;
        code_out         <= code;
        memAddress_out   <= aluResult;
        dataAlu_out      <= aluResult;
        misaligned       <= in_mis;
        writeEnabled_out <= writeEnabled & ~in_store & ~in_mis & (rd != 5'd0);
      end

      if (emit_ack) begin
        mem_req          <= 1'b0;
        out_valid        <= 1'b1;
        rd_out           <= c_rd;
        code_out         <= c_code;
        memAddress_out   <= c_alu;
        dataAlu_out      <= c_load ? load_data : c_alu;
        writeEnabled_out <= c_we & ~c_store & (c_rd != 5'd0);
      end

      if (emit_timeout) begin
        mem_req          <= 1'b0;
        out_valid        <= 1'b1;
        bus_error        <= 1'b1;
        rd_out           <= c_rd;
        code_out         <= c_code;
        memAddress_out   <= c_alu;
        dataAlu_out      <= c_alu;
        writeEnabled_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] code;
  logic [4:0]  rd;
  logic        writeEnabled;
  logic [31:0] aluResult, storeData;
  logic        stall, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        out_valid, writeEnabled_out, misaligned, bus_error;
  logic [4:0]  rd_out;
  logic [11:0] code_out;
  logic [31:0] dataAlu_out, memAddress_out;

  logic auto_mem = 1'b1;
  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  assign mem_ack = auto_mem ? auto_ack : man_ack;

  memory_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .code(code), .rd(rd),
    .writeEnabled(writeEnabled), .aluResult(aluResult), .storeData(storeData),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .out_valid(out_valid), .rd_out(rd_out),
    .writeEnabled_out(writeEnabled_out), .code_out(code_out),
    .dataAlu_out(dataAlu_out), .memAddress_out(memAddress_out),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic        we;
    logic [11:0] code;
    logic [31:0] data;
    logic        chk_data;
    logic [31:0] addr;
    logic        mis;
    logic        berr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          k;      // ack delay in cycles, 0 = never ack
    logic [31:0] rdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_AL = 7'b0110011;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one instruction at the first non-stalled cycle and record what the
  // stage and the memory should do with it.
  task automatic issue(input logic [11:0] c, input logic [4:0] r, input logic w,
                       input logic [31:0] a, input logic [31:0] s, input int k,
                       input logic [31:0] rdata);
    int guard, size, off;
    bit ld, st, sgn;
    logic [2:0]  f3;
    logic [31:0] lane, v;
    exp_t e;
    req_t q;
    guard = 0;
    @(negedge clk);
    while (stall && guard < 100) begin
      in_valid = 1'b1;
      code = 12'($urandom);
      rd = 5'($urandom);
      writeEnabled = 1'b1;
      aluResult = $urandom;
      storeData = $urandom;
      @(negedge clk);
      guard++;
    end
    if (stall) begin
      chk("stall_bound", 32'(stall), 32'd0);
      return;
    end
    in_valid = 1'b1;
    code = c;
    rd = r;
    writeEnabled = w;
    aluResult = a;
    storeData = s;

    f3 = c[9:7];
    ld = (c[6:0] == OP_LD);
    st = (c[6:0] == OP_ST);
    size = 4;
    sgn = 1'b0;
    if (ld) begin
      if (f3 == 3'd0 || f3 == 3'd4) size = 1;
      else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
      sgn = (f3 < 3'd4);
    end else if (st) begin
      if (f3 == 3'd0) size = 1;
      else if (f3 == 3'd1) size = 2;
    end
    off = int'(a[1:0]);
    e.cyc = cyc + 1;
    e.rd = r;
    e.code = c;
    e.addr = a;
    e.data = a;
    e.chk_data = 1'b1;
    e.berr = 1'b0;
    e.mis = (ld || st) && (off % size != 0);
    if ((ld || st) && !e.mis) begin
      q.addr = a & ~32'h3;
      q.we = st;
      q.be = (size == 1) ? 4'b0001 : (size == 2) ? 4'b0011 : 4'b1111;
      q.be = q.be << off;
      q.wdata = (size == 1) ? {4{s[7:0]}} : (size == 2) ? {2{s[15:0]}} : s;
      q.k = k;
      q.rdata = rdata;
      req_q.push_back(q);
      if (k == 0) begin
        e.berr = 1'b1;
        e.cyc += TO;
        e.chk_data = 1'b0;
      end else begin
        e.cyc += k;
        if (ld) begin
          lane = rdata >> (8 * off);
          if (size == 1) begin
            v = lane & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
          end else if (size == 2) begin
            v = lane & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
          end else begin
            v = rdata;
          end
          e.data = v;
        end
      end
    end else if (ld) begin
      e.chk_data = 1'b0;
    end
    e.we = w && !st && !e.mis && !e.berr && (r != 5'd0);
    exp_q.push_back(e);
  endtask

  // Memory responder: checks each request against the scoreboard and acks
  // it after the planned delay (or never, forcing a timeout).
  initial begin
    req_t q;
    int guard;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!auto_mem) continue;
      auto_ack = 1'b0;
      mem_rdata = $urandom;
      if (rst) continue;
      if (mem_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_mem_req", 32'(mem_req), 32'd0);
          guard = 0;
          while (mem_req && guard < 50) begin @(negedge clk); guard++; end
          continue;
        end
        q = req_q.pop_front();
        chk("mem_addr", mem_addr, q.addr);
        chk("mem_we", 32'(mem_we), 32'(q.we));
        chk("stall_in_wait", 32'(stall), 32'd1);
        if (q.we) begin
          chk("mem_be", 32'(mem_be), 32'(q.be));
          chk("mem_wdata", mem_wdata, q.wdata);
        end
        if (q.k != 0) begin
          repeat (q.k - 1) @(negedge clk);
          mem_rdata = q.rdata;
          auto_ack = 1'b1;
          @(negedge clk);
          auto_ack = 1'b0;
          mem_rdata = $urandom;
        end else begin
          repeat (TO) @(negedge clk);
        end
        chk("mem_req_drop", 32'(mem_req), 32'd0);
      end else if ($urandom_range(0, 7) == 0) begin
        auto_ack = 1'b1;   // stray ack while idle must be ignored
      end
    end
  end

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_cycle", 32'(cyc), 32'(e.cyc));
          chk("rd_out", 32'(rd_out), 32'(e.rd));
          chk("code_out", 32'(code_out), 32'(e.code));
          chk("memAddress_out", memAddress_out, e.addr);
          chk("writeEnabled_out", 32'(writeEnabled_out), 32'(e.we));
          chk("misaligned", 32'(misaligned), 32'(e.mis));
          chk("bus_error", 32'(bus_error), 32'(e.berr));
          if (e.chk_data) chk("dataAlu_out", dataAlu_out, e.data);
        end
      end else if (misaligned || bus_error) begin
        chk("stray_flag", 32'({misaligned, bus_error}), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [11:0] c;
    logic [31:0] a;
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    code = '0;
    rd = '0;
    writeEnabled = 1'b0;
    aluResult = '0;
    storeData = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_dataAlu_out", dataAlu_out, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    rst = 1'b0;

    issue({2'b00, 3'b000, OP_AL}, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 0, 32'h0);
    issue({2'b00, 3'b000, OP_LD}, 5'd7, 1'b1, 32'h0000_0103, 32'h0, 3, 32'h80FF_7F01);
    issue({2'b00, 3'b100, OP_LD}, 5'd7, 1'b1, 32'h0000_0103, 32'h0, 3, 32'h80FF_7F01);
    issue({2'b00, 3'b001, OP_ST}, 5'd9, 1'b1, 32'h0000_0202, 32'hAAAA_BEEF, 2, 32'h0);
    issue({2'b00, 3'b010, OP_LD}, 5'd4, 1'b1, 32'h0000_0301, 32'h0, 1, 32'h0);
    issue({2'b00, 3'b010, OP_ST}, 5'd0, 1'b0, 32'h0000_0040, 32'h1234_5678, 0, 32'h0);
    issue({2'b00, 3'b000, OP_AL}, 5'd6, 1'b1, 32'h0000_0077, 32'h0, 0, 32'h0);
    issue({2'b00, 3'b010, OP_LD}, 5'd8, 1'b1, 32'h0000_0500, 32'h0, TO, 32'hCAFE_F00D);
    issue({2'b00, 3'b101, OP_LD}, 5'd0, 1'b1, 32'h0000_0602, 32'h0, 1, 32'h8001_7FFF);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        aluResult = $urandom;
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = OP_LD;
        4, 5, 6:    op = OP_ST;
        default: begin
          op = 7'($urandom);
          if (op == OP_LD || op == OP_ST) op = OP_AL;
        end
      endcase
      c = {2'($urandom), 3'($urandom), op};
      a = $urandom;
      if ($urandom_range(0, 9) < 4) a = a & ~32'h3;
      issue(c, 5'($urandom), 1'($urandom), a, $urandom,
            $urandom_range(0, TO), $urandom);
    end

    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0 || stall) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_results", 32'(exp_q.size()), 32'd0);
    chk("drain_requests", 32'(req_q.size()), 32'd0);

    // Reset while a load is outstanding, then a late ack in IDLE.
    auto_mem = 1'b0;
    man_ack = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    code = {2'b00, 3'b010, OP_LD};
    rd = 5'd3;
    writeEnabled = 1'b1;
    aluResult = 32'h0000_0400;
    @(negedge clk);
    in_valid = 1'b0;
    chk("wait_mem_req", 32'(mem_req), 32'd1);
    chk("wait_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_rd_out", 32'(rd_out), 32'd0);
    chk("abort_code_out", 32'(code_out), 32'd0);
    chk("abort_dataAlu_out", dataAlu_out, 32'd0);
    chk("abort_memAddress_out", memAddress_out, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("late_ack_out_valid", 32'(out_valid), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    auto_mem = 1'b1;

    issue({2'b00, 3'b000, OP_AL}, 5'd12, 1'b1, 32'hDEAD_0001, 32'h0, 0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the in-order core pipeline, sitting directly upstream of the writeback stage. Takes the executed instruction (ALU result, store data, rd, write enable, 12-bit code), performs loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/ack data-memory port, and produces a registered result bundle for writeback. Non-memory instructions pass through with one cycle of latency. It flags misaligned accesses and memory timeouts and stalls upstream while a memory transaction is in flight.

## Interface
- TIMEOUT, 16, cycles in WAIT without `mem_ack` before bus error; legal range 2..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is presented this cycle.
- code  in  12  [6:0] opcode, [9:7] funct3, [11:10] ignored.
- rd  in  5  destination register.
- writeEnabled  in  1  instruction writes rd.
- aluResult  in  32  ALU result; the effective address for loads and stores.
- storeData  in  32  rs2 value for stores.
- stall  out  1  upstream must hold its outputs; equals `state == WAIT`.
- mem_req  out  1  registered memory request; held until ack or timeout.
- mem_we  out  1  1 = store.
- mem_be  out  4  byte enables.
- mem_addr  out  32  `{aluResult[31:2], 2'b00}`.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word; valid with `mem_ack`.
- mem_ack  in  1  one-cycle completion pulse.
- out_valid, rd_out (5), writeEnabled_out, code_out (12), dataAlu_out (32), memAddress_out (32)  out  registered bundle for writeback.
- misaligned  out  1  registered; valid with `out_valid`.
- bus_error  out  1  registered; valid with `out_valid`.

## Operation
- Load is opcode 0000011; store is opcode 0100011; every other opcode is non-memory.
- Decode (funct3):
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Other funct3 values are treated as LW.
  - Stores: 000 SB, 001 SH, 010 SW. Other funct3 values are treated as SW.
- Alignment rules:
  - Halfword access with `addr[0]=1` is misaligned.
  - Word access with `addr[1:0]≠0` is misaligned.
  - Misaligned accesses issue no memory request.
- Store byte lanes:
  - SB: `mem_be = 1 << addr[1:0]`, wdata `{4{sd[7:0]}}`.
  - SH: `mem_be = 0011` or `1100` by `addr[1]`, wdata `{2{sd[15:0]}}`.
  - SW: `mem_be = 1111`, wdata `sd`.
- Load data: select the byte/halfword lane by `addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- FSM states: IDLE and WAIT.
  - **IDLE** with `in_valid`:
    - Capture the instruction.
    - If the access is an aligned memory op: next edge sets `mem_req=1`, drives `mem_we/mem_be/mem_addr/mem_wdata`, clears the timeout counter, and moves to WAIT.
    - Otherwise (non-memory or misaligned): next edge emits the result (`out_valid=1`) and the FSM stays in IDLE.
  - **WAIT**:
    - `in_valid` is ignored.
    - The counter increments every cycle.
    - On `mem_ack`: next edge emits the result, clears `mem_req`, and returns to IDLE.
    - If the counter reaches TIMEOUT-1 without ack: next edge clears `mem_req`, emits a result with `bus_error=1`, and returns to IDLE.
    - Ack and timeout in the same cycle: the ack wins.
- Result fields:
  - `rd_out`, `code_out`, `memAddress_out = aluResult`.
  - `dataAlu_out` = extended load data for loads; `aluResult` otherwise.
  - `writeEnabled_out = writeEnabled & ~isStore & ~misaligned & ~bus_error & (rd≠0)`.
- `out_valid`, `misaligned`, and `bus_error` are single-cycle pulses. The other bundle outputs hold their last value.
- `mem_ack` while in IDLE is ignored.

## Timing
- Reset values:
  - `out_valid`, `writeEnabled_out`, `misaligned`, `bus_error`, `mem_req`, `mem_we`: 0.
  - `rd_out`, `code_out`, `dataAlu_out`, `memAddress_out`, `mem_be`, `mem_addr`, `mem_wdata`: 0.
  - FSM in IDLE, counter at 0.
- Reset asserted in WAIT: `mem_req` drops at that edge and no result is emitted. Memory must tolerate the abandoned request.
- Non-memory or misaligned accept at edge T: `out_valid` is high in cycle T+1. Back-to-back accepts give one result per cycle.
- Memory accept at edge T:
  - `mem_req` and `stall` are high from T+1.
  - With ack sampled at edge T+k (k≥1): `out_valid` is high in T+k+1, and `stall` is low from T+k+1.
- Zero-wait memory (ack in the first WAIT cycle): 2-cycle latency.
- Timeout: `bus_error` is asserted in cycle T+TIMEOUT+1.
- Upstream holds its next instruction while `stall=1`. This block captures it in the first IDLE cycle.

## Test plan
- ADD-type, `aluResult=0x1234`, rd=5, we=1 -> next cycle `out_valid=1`, `dataAlu_out=0x1234`, `rd_out=5`, `writeEnabled_out=1`, `mem_req` never asserted.
- LB at addr 0x103, `mem_rdata=0x80FF_7F01`, ack after 3 cycles -> `mem_addr=0x100`, `dataAlu_out=0xFFFF_FF80`, `stall` high for exactly 3 cycles. The same access as LBU gives `0x0000_0080`.
- SH at 0x202, `storeData=0xAAAA_BEEF` -> `mem_we=1`, `mem_be=1100`, `mem_wdata=0xBEEF_BEEF`, `writeEnabled_out=0` after ack.
- LW at 0x301 -> no `mem_req`, next cycle `out_valid=1`, `misaligned=1`, `writeEnabled_out=0`.
- SW with no ack, TIMEOUT=4 -> `mem_req` high 4 cycles then low, `bus_error=1` pulse, FSM back in IDLE, next ADD accepted.
- LW in WAIT, `rst` pulsed for one cycle -> `mem_req=0` and all outputs at reset values after that edge, no `out_valid`; a late `mem_ack` in IDLE is ignored.
